// File: rtl/cdpga_chk_pkg.sv
// Shared types and helpers for the cdpga `out` bus checker.
// The gray2bin helper only exists when CDPGA_CHK_GRAY_EN is defined.
package cdpga_chk_pkg;

  typedef enum logic {SEARCH = 1'b0, LOCK = 1'b1} state_t;

  localparam int ERR_CNT_W = 16;

`ifdef CDPGA_CHK_GRAY_EN
  // Wide enough for any practical bus; zero-extended upper bits do not
  // disturb the lower bits of the conversion.
  localparam int GRAY_MAX_W = 64;

  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
`endif

endpackage

// File: rtl/cdpga_sync_settle.sv
// Two-flop bitwise synchronizer for the asynchronous bus plus a settle
// filter: a synchronized value is offered for acceptance once it has held
// for SETTLE cycles and differs from the last accepted value.
module cdpga_sync_settle
  import cdpga_chk_pkg::*;
#(
  parameter int W      = 20,
  parameter int SETTLE = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  input  logic [W-1:0] last_val,
  output logic         acc_stb,
  output logic [W-1:0] acc_val
);

  // +2 keeps the counter at least one bit wide for tiny SETTLE values
  localparam int HW = $clog2(SETTLE + 2);

  logic [W-1:0]  meta;
  logic [W-1:0]  s;
  logic [HW-1:0] hcnt;   // cycles s has held its current value, capped at SETTLE

  // synchronizer stages and hold counter; a change restarts the count at 1
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= '0;
      s    <= '0;
      hcnt <= '0;
    end else begin
      meta <= din;
      s    <= meta;
      if (meta != s)                hcnt <= HW'(1);
      else if (hcnt != HW'(SETTLE)) hcnt <= hcnt + 1'b1;
    end
  end

  assign acc_val = s;
  assign acc_stb = (hcnt == HW'(SETTLE)) && (s != last_val);

endmodule

// File: rtl/cdpga_out_checker.sv
// Receiving-end checker for the cdpga_h `out` bus: tracks the stepping
// counter pattern, reports lock, stall and step errors.
// Define CDPGA_CHK_GRAY_EN to check a Gray-coded counter instead of binary.
module cdpga_out_checker
  import cdpga_chk_pkg::*;
#(
  parameter int W       = 20,
  parameter int LOCK_N  = 4,
  parameter int TIMEOUT = 1000000,
  parameter int SETTLE  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [W-1:0]         din,
  input  logic                 clr,
  output logic                 locked,
  output logic                 stall,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [W-1:0]         last_val
);

  localparam int IW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(LOCK_N + 1);

  logic          acc_stb;
  logic [W-1:0]  acc_val;
  logic          good;
  state_t        state;
  logic [IW-1:0] idle_cnt;
  logic [IW-1:0] idle_nxt;
  logic [GW-1:0] good_cnt;

  cdpga_sync_settle #(.W(W), .SETTLE(SETTLE)) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .last_val (last_val),
    .acc_stb  (acc_stb),
    .acc_val  (acc_val)
  );

`ifdef CDPGA_CHK_GRAY_EN
  // Gray step: exactly one bit flips and the decoded count advances by one
  logic [W-1:0] cand_b;
  logic [W-1:0] last_b;
  logic [W-1:0] last_inc;
  assign cand_b   = W'(gray2bin(GRAY_MAX_W'(acc_val)));
  assign last_b   = W'(gray2bin(GRAY_MAX_W'(last_val)));
  assign last_inc = last_b + W'(1);
  assign good     = ($countones(acc_val ^ last_val) == 1) && (cand_b == last_inc);
`else
  // binary step: candidate is last value plus one, wrapping to zero
  logic [W-1:0] last_inc;
  assign last_inc = last_val + W'(1);
  assign good     = (acc_val == last_inc);
`endif

  // idle counter next value: cleared by any acceptance, saturates at TIMEOUT
  always_comb begin
    idle_nxt = idle_cnt;
    if (acc_stb)                        idle_nxt = '0;
    else if (idle_cnt != IW'(TIMEOUT))  idle_nxt = idle_cnt + 1'b1;
  end

  // lock FSM, error counting, timeout and clear; all outputs registered
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= SEARCH;
      locked    <= 1'b0;
      stall     <= 1'b0;
      err_pulse <= 1'b0;
      err_cnt   <= '0;
      last_val  <= '0;
      idle_cnt  <= '0;
      good_cnt  <= '0;
    end else begin
      err_pulse <= 1'b0;
      // the accepted value is tracked even across a clear
      if (acc_stb) last_val <= acc_val;
      if (clr) begin
        err_cnt  <= '0;
        stall    <= 1'b0;
        idle_cnt <= '0;
        state    <= SEARCH;
        locked   <= 1'b0;
        good_cnt <= '0;
      end else begin
        idle_cnt <= idle_nxt;
        stall    <= (idle_nxt == IW'(TIMEOUT));
        case (state)
          SEARCH: begin
            if (acc_stb) begin
              if (!good) begin
                good_cnt <= '0;
              end else if (good_cnt == GW'(LOCK_N - 1)) begin
                good_cnt <= GW'(LOCK_N);
                state    <= LOCK;
                locked   <= 1'b1;
              end else begin
                good_cnt <= good_cnt + 1'b1;
              end
            end
          end
          LOCK: begin
            if (acc_stb && !good) begin
              err_pulse <= 1'b1;
              if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
              state    <= SEARCH;
              locked   <= 1'b0;
              good_cnt <= '0;
            end else if (idle_nxt == IW'(TIMEOUT)) begin
              // a stalled bus loses lock silently
              state    <= SEARCH;
              locked   <= 1'b0;
              good_cnt <= '0;
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cdpga_out_checker.sv
// Scoreboard bench for cdpga_out_checker: the driver pushes the expected
// outcome of each new bus value into a queue, a monitor pops and compares
// whenever last_val changes.
module tb_cdpga_out_checker;

  localparam int W       = 20;
  localparam int LOCK_N  = 4;
  localparam int TIMEOUT = 64;
  localparam int SETTLE  = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  din;
  logic          clr;
  logic          locked;
  logic          stall;
  logic          err_pulse;
  logic [15:0]   err_cnt;
  logic [W-1:0]  last_val;

  cdpga_out_checker #(.W(W), .LOCK_N(LOCK_N), .TIMEOUT(TIMEOUT), .SETTLE(SETTLE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .clr       (clr),
    .locked    (locked),
    .stall     (stall),
    .err_pulse (err_pulse),
    .err_cnt   (err_cnt),
    .last_val  (last_val)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] val;
    logic         lk;
    logic         ep;
    logic [15:0]  ec;
  } exp_t;

  exp_t         q[$];
  exp_t         e;
  int           errors = 0;
  int           checks = 0;
  logic [W-1:0] m_last;
  bit           m_lock;
  int           m_good;
  int           m_err;
  logic [W-1:0] prev_lv = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    b = '0;
    for (int i = W-1; i >= 0; i--) b[i] = ((i == W-1) ? 1'b0 : b[i+1]) ^ g[i];
    return b;
  endfunction

  // count domain <-> bus encoding
  function automatic logic [W-1:0] enc(input logic [W-1:0] n);
`ifdef CDPGA_CHK_GRAY_EN
    return n ^ (n >> 1);
`else
    return n;
`endif
  endfunction

  function automatic logic [W-1:0] dec(input logic [W-1:0] x);
`ifdef CDPGA_CHK_GRAY_EN
    return g2b(x);
`else
    return x;
`endif
  endfunction

  function automatic bit is_good(input logic [W-1:0] c, input logic [W-1:0] l);
`ifdef CDPGA_CHK_GRAY_EN
    return ($countones(c ^ l) == 1) && (g2b(c) == W'(g2b(l) + 1));
`else
    return c == W'(l + 1);
`endif
  endfunction

  function automatic logic [W-1:0] nxt(input logic [W-1:0] x);
    return enc(W'(dec(x) + 1));
  endfunction

  task automatic model_reset();
    m_last = '0; m_lock = 0; m_good = 0; m_err = 0;
  endtask

  // expected outcome of accepting bus value c
  task automatic model_step(input logic [W-1:0] c, input bit with_clr);
    exp_t x;
    bit   g;
    if (c == m_last) return;
    g = is_good(c, m_last);
    x.ep = 1'b0;
    if (with_clr) begin
      m_err = 0; m_lock = 0; m_good = 0;
    end else if (m_lock) begin
      if (!g) begin
        x.ep = 1'b1;
        if (m_err < 65535) m_err++;
        m_lock = 0; m_good = 0;
      end
    end else if (g) begin
      m_good++;
      if (m_good >= LOCK_N) m_lock = 1;
    end else begin
      m_good = 0;
    end
    m_last = c;
    x.val = c; x.lk = m_lock; x.ec = 16'(m_err);
    q.push_back(x);
  endtask

  // drive v for hold cycles; optionally pulse clr on the acceptance edge
  task automatic put(input logic [W-1:0] v, input int hold, input bit with_clr);
    model_step(v, with_clr);
    din = v;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      clr = with_clr && (i == SETTLE);
    end
    clr = 1'b0;
  endtask

  task automatic relock();
    for (int i = 0; i < LOCK_N; i++) put(nxt(m_last), 3, 0);
    put(nxt(m_last), 5, 0);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    m_err = 0; m_lock = 0; m_good = 0;
  endtask

  // monitor: every change of last_val is one acceptance
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_lv = last_val;
      end else if (last_val !== prev_lv) begin
        prev_lv = last_val;
        if (q.size() == 0) begin
          chk("unexpected_accept", last_val, {W{1'bx}});
        end else begin
          e = q.pop_front();
          chk("acc_val", last_val, e.val);
          chk("acc_locked", locked, e.lk);
          chk("acc_err_pulse", err_pulse, e.ep);
          chk("acc_err_cnt", err_cnt, e.ec);
        end
      end else begin
        chk("idle_err_pulse", err_pulse, 0);
      end
    end
  end

  // watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] v;
    rst_n = 1'b0; din = '0; clr = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_locked", locked, 0);
    chk("rst_stall", stall, 0);
    chk("rst_err_pulse", err_pulse, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_last_val", last_val, 0);

    // 1: lock on 0..4, locked exactly 2+SETTLE cycles after din=4
    for (int n = 1; n < 4; n++) put(enc(W'(n)), 8, 0);
    model_step(enc(W'(4)), 0);
    din = enc(W'(4));
    repeat (1 + SETTLE) @(negedge clk);
    chk("lock_early", locked, 0);
    @(negedge clk);
    chk("lock_latency", locked, 1);
    repeat (4) @(negedge clk);
    chk("t1_err_cnt", err_cnt, 0);

    // 2: bad step while locked, then relock
    put(enc(W'(5)), 4, 0);
    put(enc(W'(6)), 4, 0);
    put(enc(W'(9)), 6, 0);
    chk("t2_unlocked", locked, 0);
    chk("t2_err_cnt", err_cnt, 1);
    for (int n = 10; n <= 13; n++) put(enc(W'(n)), 5, 0);
    chk("t2_relocked", locked, 1);

    // 3: wrap from all-ones to zero is a good step
    put(enc(20'hFFFFA), 4, 0);
    for (int n = 'hFFFFB; n <= 'hFFFFE; n++) put(enc(W'(n)), 4, 0);
    chk("t3_locked", locked, 1);
    put(enc(20'hFFFFF), 4, 0);
    put(enc(20'h00000), 6, 0);
    chk("t3_wrap_locked", locked, 1);
    chk("t3_wrap_val", last_val, enc(20'h0));
    chk("t3_err_cnt", err_cnt, 2);

    // 4: one-cycle glitch is filtered
    for (int n = 1; n <= 7; n++) put(enc(W'(n)), 3, 0);
    din = enc(W'(8));
    @(negedge clk);
    din = enc(W'(7));
    repeat (8) @(negedge clk);
    chk("t4_glitch_val", last_val, enc(W'(7)));
    chk("t4_glitch_err", err_cnt, 16'(m_err));
    put(enc(W'(8)), 6, 0);
    chk("t4_after_locked", locked, 1);

    // random walk with occasional glitches
    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 3) != 0) v = nxt(m_last);
      else begin
        v = W'($urandom);
        if (v == m_last) v = v ^ W'(1);
      end
      put(v, $urandom_range(3, 8), 0);
      if ($urandom_range(0, 9) == 0) begin
        din = W'($urandom);
        @(negedge clk);
        din = v;
      end
    end
    repeat (6) @(negedge clk);

    // 5: stall after TIMEOUT idle cycles
    for (int i = 0; i < LOCK_N; i++) put(nxt(m_last), 4, 0);
    chk("t5_locked", locked, 1);
    repeat (TIMEOUT - 1) @(negedge clk);
    chk("t5_no_stall_yet", stall, 0);
    chk("t5_still_locked", locked, 1);
    @(negedge clk);
    m_lock = 0; m_good = 0;
    chk("t5_stall", stall, 1);
    chk("t5_stall_unlock", locked, 0);
    chk("t5_err_kept", err_cnt, 16'(m_err));
    repeat (5) @(negedge clk);
    chk("t5_stall_held", stall, 1);
    pulse_clr();
    chk("t5_clr_stall", stall, 0);
    chk("t5_clr_err", err_cnt, 0);

    // 6: saturation (counter preloaded near the top) and clr beating a bad step
    relock();
    force dut.err_cnt = 16'hFFFC;
    #1;
    release dut.err_cnt;
    m_err = 'hFFFC;
    @(negedge clk);
    chk("t6_preload", err_cnt, 16'hFFFC);
    for (int i = 0; i < 4; i++) begin
      put(enc(W'(dec(m_last) + 3)), 5, 0);
      relock();
    end
    chk("t6_saturated", err_cnt, 16'hFFFF);
    put(enc(W'(dec(m_last) + 3)), SETTLE + 4, 1);
    chk("t6_clr_err", err_cnt, 0);
    chk("t6_clr_unlocked", locked, 0);

    // mid-run reset clears everything, including the synchronizer
    put(nxt(m_last), 6, 0);
    din = enc(W'(5));
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    din = '0;
    rst_n = 1'b1;
    model_reset();
    chk("mrst_last_val", last_val, 0);
    chk("mrst_err_cnt", err_cnt, 0);
    chk("mrst_locked", locked, 0);
    repeat (8) @(negedge clk);
    chk("mrst_no_accept", last_val, 0);
    put(enc(W'(1)), 6, 0);

    repeat (4) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
